// File: rtl/gmii_frame_gen.sv
// GMII transmit stimulus source: preamble, SFD, incrementing/LFSR payload and IFG, with optional single TX_ER per frame.
// All outputs registered one cycle behind the FSM state; no backpressure, the PCS always accepts a byte per cycle.
module gmii_frame_gen #(
    parameter int         PREAMBLE_LEN = 7,
    parameter int         IFG_MIN      = 12,
    parameter int         LEN_W        = 16,
    parameter int         CNT_W        = 16,
    parameter logic [7:0] SEED         = 8'h01
) (
    input  logic             Clk,
    input  logic             mr_main_reset,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [LEN_W-1:0] frame_len,
    input  logic [CNT_W-1:0] num_frames,
    input  logic [7:0]       ifg,
    input  logic             err_en,
    input  logic [LEN_W-1:0] err_index,
    output logic [7:0]       TXD,
    output logic             TX_EN,
    output logic             TX_ER,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] frames_sent
);

    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, GAP} state_t;

    localparam logic [LEN_W-1:0] PRE_LAST = LEN_W'(PREAMBLE_LEN - 1);
    localparam logic [7:0]       GAP_MIN  = 8'(IFG_MIN);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] eidx_q, eidx_d;
    logic [CNT_W-1:0] nfr_q, nfr_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic [7:0]       gap_q, gap_d;
    logic [7:0]       pay_q, pay_d;
    logic [7:0]       txd_q, txd_d;
    logic             mode_q, mode_d;
    logic             een_q, een_d;
    logic             stop_q, stop_d;
    logic             en_q, en_d;
    logic             er_q, er_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        eidx_d  = eidx_q;
        nfr_d   = nfr_q;
        burst_d = burst_q;
        sent_d  = sent_q;
        gap_d   = gap_q;
        pay_d   = pay_q;
        mode_d  = mode_q;
        een_d   = een_q;
        txd_d   = 8'h00;
        en_d    = 1'b0;
        er_d    = 1'b0;
        done_d  = 1'b0;
        busy_d  = (state_q != IDLE);
        // stop is sticky once captured while busy; only the transition to IDLE clears it
        stop_d  = stop_q | (stop && state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PRE;
                    cnt_d   = '0;
                    len_d   = (frame_len == '0) ? LEN_W'(1) : frame_len;
                    eidx_d  = err_index;
                    nfr_d   = num_frames;
                    burst_d = '0;
                    gap_d   = (ifg < GAP_MIN) ? GAP_MIN : ifg;
                    mode_d  = mode;
                    een_d   = err_en;
                end
            end
            PRE: begin
                en_d  = 1'b1;
                txd_d = 8'h55;
                if (cnt_q == PRE_LAST) begin
                    state_d = SFD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            SFD: begin
                en_d    = 1'b1;
                txd_d   = 8'hD5;
                state_d = DATA;
                cnt_d   = '0;
                pay_d   = SEED;
            end
            DATA: begin
                en_d  = 1'b1;
                txd_d = pay_q;
                er_d  = een_q && (cnt_q == eidx_q);
                pay_d = mode_q ? {pay_q[6:0], pay_q[7] ^ pay_q[5] ^ pay_q[4] ^ pay_q[3]}
                               : pay_q + 8'd1;
                if (cnt_q == len_q - LEN_W'(1)) begin
                    done_d  = 1'b1;
                    sent_d  = sent_q + CNT_W'(1);
                    burst_d = burst_q + CNT_W'(1);
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == LEN_W'(gap_q) - LEN_W'(1)) begin
                    cnt_d = '0;
                    if (stop_d || (nfr_q != '0 && burst_q == nfr_q)) begin
                        state_d = IDLE;
                        stop_d  = 1'b0;
                    end else begin
                        state_d = PRE;
                    end
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            eidx_q  <= '0;
            nfr_q   <= '0;
            burst_q <= '0;
            sent_q  <= '0;
            gap_q   <= '0;
            pay_q   <= '0;
            mode_q  <= 1'b0;
            een_q   <= 1'b0;
            stop_q  <= 1'b0;
            txd_q   <= 8'h00;
            en_q    <= 1'b0;
            er_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            eidx_q  <= eidx_d;
            nfr_q   <= nfr_d;
            burst_q <= burst_d;
            sent_q  <= sent_d;
            gap_q   <= gap_d;
            pay_q   <= pay_d;
            mode_q  <= mode_d;
            een_q   <= een_d;
            stop_q  <= stop_d;
            txd_q   <= txd_d;
            en_q    <= en_d;
            er_q    <= er_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign TXD         = txd_q;
    assign TX_EN       = en_q;
    assign TX_ER       = er_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign frames_sent = sent_q;

endmodule

// File: doc/gmii_frame_gen.md
# gmii_frame_gen

Parametrised, synthesizable GMII-side frame generator that drives TXD/TX_EN/TX_ER into the PCS transmit path, replacing hand-sequenced byte stimulus. It emits back-to-back frames made of configurable preamble, SFD, payload and inter-frame gap, and can inject a single TX_ER error per frame. It sits upstream of the transmitter in loopback tests. It also runs standalone as a traffic source for the transmit/sync/receive chain.

## Interface

Parameters:
- PREAMBLE_LEN, 7: number of 0x55 preamble bytes before SFD (1..15).
- IFG_MIN, 12: minimum inter-frame gap in cycles; smaller `ifg` requests are raised to this.
- LEN_W, 16: width of `frame_len` and the internal byte counter.
- CNT_W, 16: width of `num_frames` and `frames_sent`.
- SEED, 8'h01: first payload byte of every frame (both modes).

Ports:
- Clk  in  1  system clock, rising-edge.
- mr_main_reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a burst; sampled only in IDLE.
- stop  in  1  finish the current frame and its IFG, then return to IDLE.
- mode  in  1  payload mode: 0 = incrementing, 1 = LFSR.
- frame_len  in  LEN_W  payload bytes per frame; latched at start.
- num_frames  in  CNT_W  frames in the burst; 0 = continuous until stop; latched at start.
- ifg  in  8  gap cycles between frames; latched at start.
- err_en  in  1  enable error injection; latched at start.
- err_index  in  LEN_W  payload byte index (0-based) that carries TX_ER; latched at start.
- TXD  out  8  GMII data.
- TX_EN  out  1  GMII transmit enable.
- TX_ER  out  1  GMII transmit error.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse on the last payload byte of each frame.
- frames_sent  out  CNT_W  frames completed since reset; wraps modulo 2^CNT_W.

## Operation

- All outputs are registered.
- States and transitions:
  - IDLE goes to PRE on `start`.
  - PRE lasts PREAMBLE_LEN cycles, then goes to SFD.
  - SFD lasts 1 cycle, then goes to DATA.
  - DATA lasts `frame_len` cycles, then goes to GAP.
  - GAP lasts max(`ifg`, IFG_MIN) cycles, then goes to PRE or IDLE.
- Outputs by state:
  - PRE: TX_EN=1, TXD=0x55.
  - SFD: TX_EN=1, TXD=0xD5.
  - DATA: TX_EN=1, TXD=payload byte.
  - GAP and IDLE: TX_EN=0, TXD=0x00, TX_ER=0.
- GAP exit rule: go to IDLE if `stop` was seen since start, or if num_frames≠0 and frames_sent-in-burst equals num_frames; otherwise go to PRE.
- `stop` is sticky: a one-cycle pulse at any time while busy is captured. It is cleared on entry to IDLE.
- `frame_len` of 0 is treated as 1.
- Payload, mode 0: byte k = SEED + k, mod 256 (wraps 0xFF→0x00).
- Payload, mode 1: byte 0 = SEED. Each next byte is {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. The LFSR is reloaded with SEED at each SFD.
- Error injection: TX_ER=1 only during the DATA cycle whose index equals `err_index`, when err_en=1. If err_index ≥ frame_len, no error is injected.
- frames_sent increments on the same edge that frame_done asserts.
- `start` asserted while busy is ignored.

## Timing

- Reset values: TXD=0x00, TX_EN=0, TX_ER=0, busy=0, frame_done=0, frames_sent=0. State returns to IDLE and the sticky stop is cleared.
- Reset mid-frame: outputs drop to reset values asynchronously and the frame is truncated. No recovery behaviour is required.
- Start latency: `start` high at edge N gives TX_EN=1, TXD=0x55 after edge N+1.
- Frame length on the wire: TX_EN is high for exactly PREAMBLE_LEN+1+frame_len consecutive cycles.
- Gap: TX_EN is low for exactly max(ifg, IFG_MIN) cycles between frames.
- frame_done coincides with the last DATA byte.
- busy rises with the first PRE cycle and falls on the first IDLE cycle after the final GAP.
- Inputs are synchronous to Clk. `start` and `stop` are level-sampled at each rising edge.

## Test plan

- Reset, then start with frame_len=4, mode=0, num_frames=1, ifg=0 (defaults) -> expect:
  - TXD = 0x55×7, 0xD5, 0x01, 0x02, 0x03, 0x04 with TX_EN=1 for 12 cycles;
  - frame_done with 0x04; frames_sent=1;
  - TX_EN low for 12 cycles, then busy=0.
- mode=1, frame_len=5, SEED=0x01 -> payload 0x01, 0x02, 0x04, 0x08, 0x11; the second frame repeats the same sequence.
- err_en=1, err_index=2, frame_len=4 -> TX_ER=1 only on the cycle TXD=0x03. Repeat with err_index=9: TX_ER never asserts.
- num_frames=0, ifg=20, stop pulsed mid-payload of frame 3 -> frame 3 completes with its 20-cycle gap, then IDLE with frames_sent=3. A `start` pulsed during the burst has no effect.
- num_frames=2, frame_len=0 -> two frames of one payload byte (0x01) each, separated by 12 idle cycles (ifg clamped to IFG_MIN).
- mr_main_reset asserted during the DATA state -> TX_EN, TX_ER, busy and frames_sent go to 0 without waiting for a clock edge. After release with no start, outputs stay idle.
